// File: rtl/dp_acc_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_acc_4_pkg
// Description : Iteration constants shared by the 16-sample accumulator
//               datapath and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_acc_4_pkg;

    localparam int unsigned ITR_W    = 4;
    localparam int unsigned N_ITER   = 16;
    localparam logic [3:0]  ITR_LAST = 4'd15;
    localparam int unsigned DEF_DW   = 8;

    // Accumulator width needed so N_ITER unsigned samples of width dw never overflow.
    function automatic int unsigned sum_width(input int unsigned dw);
        return dw + ITR_W;
    endfunction

endpackage : dp_acc_4_pkg
`default_nettype wire

// File: rtl/dp_acc_4_cnt_itr_4.sv
`default_nettype none
// ============================================================================
// Module      : cnt_itr_4
// Description : 4-bit iteration counter, synchronous clear dominates enable,
//               wraps 15 -> 0 silently.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_itr_4
    import dp_acc_4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [ITR_W-1:0] itr
);

    logic [ITR_W-1:0] r_itr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_itr <= '0;
        end else if (en) begin
            r_itr <= r_itr + 1'b1;
        end
    end

    assign itr = r_itr;

endmodule : cnt_itr_4
`default_nettype wire

// File: rtl/dp_acc_4.sv
`default_nettype none
// ============================================================================
// Module      : dp_acc_4
// Description : Clears on init, accumulates one sample per ld, captures the
//               sum on fin into a valid/ack output register with sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_acc_4
    import dp_acc_4_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned SW = sum_width(DW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             ld,
    input  logic             fin,
    input  logic [DW-1:0]    data_in,
    input  logic             out_ack,
    output logic [ITR_W-1:0] itr,
    output logic [SW-1:0]    sum_out,
    output logic             out_valid,
    output logic             overrun
);

    logic [SW-1:0] r_acc;
    logic [SW-1:0] r_sum;
    logic          r_valid;
    logic          r_overrun;
    logic [SW-1:0] w_sample;

    assign w_sample = {{(SW-DW){1'b0}}, data_in};

    cnt_itr_4 u_cnt_itr (
        .clk (clk),
        .rst (rst),
        .clr (init),
        .en  (ld),
        .itr (itr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (init) begin
            r_acc <= '0;
        end else if (ld) begin
            r_acc <= r_acc + w_sample;
        end
    end

    // fin captures the pre-add accumulator even if ld is active on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (fin) begin
            r_sum   <= r_acc;
            r_valid <= 1'b1;
            if (r_valid && !out_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (out_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign sum_out   = r_sum;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule : dp_acc_4
`default_nettype wire

// File: tb/tb_dp_acc_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_acc_4
// Description : Scoreboard bench for dp_acc_4 against a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_acc_4;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 12;

    typedef struct {
        int unsigned itr;
        int unsigned sum;
        bit          valid;
        bit          ov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, init, ld, fin, out_ack;
    logic [DW-1:0] data_in;
    logic [3:0]    itr;
    logic [SW-1:0] sum_out;
    logic          out_valid, overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    bit   done = 1'b0;

    // Reference model state: plain integers, sums taken modulo 2**SW.
    int unsigned m_acc = 0, m_itr = 0, m_sum = 0;
    bit          m_valid = 1'b0, m_ov = 1'b0;

    dp_acc_4 #(.DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .ld        (ld),
        .fin       (fin),
        .data_in   (data_in),
        .out_ack   (out_ack),
        .itr       (itr),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit i, input bit l, input bit f,
                              input int unsigned d, input bit a);
        exp_t e;
        if (r) begin
            m_acc = 0; m_itr = 0; m_sum = 0; m_valid = 0; m_ov = 0;
        end else begin
            if (f) begin
                if (m_valid && !a) m_ov = 1;
                m_sum   = m_acc;
                m_valid = 1;
            end else if (a) begin
                m_valid = 0;
            end
            if (i) begin
                m_acc = 0; m_itr = 0;
            end else if (l) begin
                m_acc = (m_acc + d) % (1 << SW);
                m_itr = (m_itr + 1) % 16;
            end
        end
        e.itr = m_itr; e.sum = m_sum; e.valid = m_valid; e.ov = m_ov;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit i, input bit l, input bit f,
                       input int unsigned d, input bit a);
        @(negedge clk);
        rst = r; init = i; ld = l; fin = f; data_in = d[DW-1:0]; out_ack = a;
        @(posedge clk);
        #1;
        model_step(r, i, l, f, d, a);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic run_job(input bit with_init, input int unsigned val);
        if (with_init) cyc(0, 1, 1, 0, 8'hFF, 0);
        for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, val, 0);
    endtask

    // Monitor: one expected snapshot per clock, compared mid-cycle.
    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (itr != e.itr[3:0] || sum_out != e.sum[SW-1:0] ||
                    out_valid != e.valid || overrun != e.ov) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got itr=%0d sum=%0d v=%0b ov=%0b, expected itr=%0d sum=%0d v=%0b ov=%0b",
                             $time, itr, sum_out, out_valid, overrun, e.itr, e.sum, e.valid, e.ov);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1; init = 0; ld = 0; fin = 0; data_in = '0; out_ack = 0;

        // Reset with activity on the control inputs.
        cyc(1, 1, 1, 1, 8'h5A, 0);
        cyc(1, 0, 1, 1, 8'hA5, 1);
        chk("reset_itr", itr, 0);
        chk("reset_sum", sum_out, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_overrun", overrun, 0);

        // Nominal job: init sample excluded, data 1..16.
        cyc(0, 1, 1, 0, 8'hFF, 0);
        for (int k = 1; k <= 16; k++) cyc(0, 0, 1, 0, k, 0);
        chk("nominal_itr_wrap", itr, 0);
        chk("nominal_valid_before_fin", out_valid, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("nominal_sum", sum_out, 136);
        chk("nominal_valid", out_valid, 1);

        // Hold without ack, then ack.
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, $urandom_range(0, 255), 0);
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum_out, 136);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ack_clears_valid", out_valid, 0);

        // Full-scale samples, left unacknowledged.
        run_job(1, 8'hFF);
        cyc(0, 0, 0, 1, 0, 0);
        chk("overflow_sum", sum_out, 4080);
        chk("overflow_overrun", overrun, 0);

        // Second job finishing over the unacked result.
        run_job(1, 2);
        cyc(0, 0, 1, 0, 9, 0);
        chk("ld_keeps_sum", sum_out, 4080);
        cyc(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, 2, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("overrun_sum", sum_out, 32);
        chk("overrun_valid", out_valid, 1);
        chk("overrun_flag", overrun, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("overrun_sticky", overrun, 1);

        // Reset mid-job at itr=7.
        cyc(0, 1, 1, 0, 3, 0);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, 3, 0);
        chk("midjob_itr", itr, 7);
        cyc(1, 0, 1, 0, 3, 0);
        chk("midjob_rst_itr", itr, 0);
        chk("midjob_rst_overrun", overrun, 0);

        // fin together with ack: new result, no overrun.
        run_job(1, 5);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("fin_ack_valid", out_valid, 1);
        chk("fin_ack_overrun", overrun, 0);
        chk("fin_ack_sum", sum_out, 80);

        // 17 loads with no intervening init wrap itr to 1.
        cyc(0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 17; k++) cyc(0, 0, 1, 0, 1, 0);
        chk("wrap_itr", itr, 1);

        // Randomised traffic, including fin with ld and ld without init.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 10),
                $urandom_range(0, 255), ($urandom_range(0, 99) < 30));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_dp_acc_4
`default_nettype wire
